sync_capture: RTL and testbench

SYNC_CAPTURE -- requirements
Module: sync_capture

---
 rtl/sync_capture.sv | 122 ++++++++++++
 tb/tb_sync_capture.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_capture.sv
// sync_capture: sync-triggered burst capture of ADC samples into a
// small FIFO, drained by a valid/ready consumer.
module sync_capture #(
  parameter int DATA_W    = 14,
  parameter int BURST_LEN = 1024,
  parameter int DEPTH     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              clear,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              burst_done,
  output logic [7:0]        frame_count,
  output logic              overflow,
  output logic              resync_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [15:0] BL = 16'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       occ_q, occ_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              done_q, done_d;
  logic [7:0]        frame_q;
  logic              ovf_q, rse_q;
  logic              wr_try, wr_en, rd_en, drop, rse_set;

  // Buffer write/read qualification; fullness is judged before the read.
  always_comb begin
    wr_try  = (state_q == CAPTURE) && adc_valid;
    wr_en   = wr_try && (occ_q != OCC_FULL);
    drop    = wr_try && (occ_q == OCC_FULL);
    rd_en   = (occ_q != '0) && out_ready;
    rse_set = sync && (state_q != IDLE);
    occ_d   = occ_q;
    if (wr_en && !rd_en) occ_d = occ_q + (AW+1)'(1);
    if (!wr_en && rd_en) occ_d = occ_q - (AW+1)'(1);
  end

  // Sequencer next state: burst counter and drain completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end
      end
      CAPTURE: begin
        if (adc_valid) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == BL) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (occ_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, pointers, counters and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      done_q   <= 1'b0;
      frame_q  <= '0;
      ovf_q    <= 1'b0;
      rse_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      done_q  <= done_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (done_d) frame_q <= frame_q + 8'd1;
      ovf_q <= drop | (ovf_q & ~clear);
      rse_q <= rse_set | (rse_q & ~clear);
    end
  end

  // Sample storage; contents are don't-care while occupancy is zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= adc_data;
  end

  assign out_valid   = (occ_q != '0);
  assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
  assign busy        = (state_q != IDLE);
  assign burst_done  = done_q;
  assign frame_count = frame_q;
  assign overflow    = ovf_q;
  assign resync_err  = rse_q;

endmodule

// File: tb/tb_sync_capture.sv
// tb_sync_capture: table vectors on a short-burst instance plus a
// scoreboard-checked long-burst instance sharing the same stimulus.
module tb_sync_capture;

  logic        clk;
  logic        reset;
  logic        sync;
  logic [13:0] adc_data;
  logic        adc_valid;
  logic        clear;
  logic        out_ready;

  logic [13:0] a_out_data, b_out_data;
  logic        a_out_valid, b_out_valid;
  logic        a_busy, b_busy;
  logic        a_burst_done, b_burst_done;
  logic [7:0]  a_frame, b_frame;
  logic        a_overflow, b_overflow;
  logic        a_resync, b_resync;

  int n_pass;
  int n_total;

  logic [13:0] sbq[$];
  int          mocc;

  typedef struct {
    logic        s;
    logic        v;
    logic [13:0] d;
    logic        r;
    logic        busy;
    logic        ov;
    logic [13:0] od;
    logic        done;
    logic [7:0]  fc;
  } vec_t;

  vec_t tbl[8];

  sync_capture #(.DATA_W(14), .BURST_LEN(4), .DEPTH(16)) u_a (
    .clk(clk), .reset(reset), .sync(sync),
    .adc_data(adc_data), .adc_valid(adc_valid), .clear(clear),
    .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(out_ready), .busy(a_busy),
    .burst_done(a_burst_done), .frame_count(a_frame),
    .overflow(a_overflow), .resync_err(a_resync)
  );

  sync_capture #(.DATA_W(14), .BURST_LEN(20), .DEPTH(16)) u_b (
    .clk(clk), .reset(reset), .sync(sync),
    .adc_data(adc_data), .adc_valid(adc_valid), .clear(clear),
    .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(out_ready), .busy(b_busy),
    .burst_done(b_burst_done), .frame_count(b_frame),
    .overflow(b_overflow), .resync_err(b_resync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
  endtask

  function automatic vec_t mk(bit s, bit v, int d, bit r, bit b,
                              bit ov, int od, bit dn, int fc);
    vec_t t;
    t.s = s; t.v = v; t.d = 14'(d); t.r = r;
    t.busy = b; t.ov = ov; t.od = 14'(od);
    t.done = dn; t.fc = 8'(fc);
    return t;
  endfunction

  task automatic do_reset();
    reset = 1'b1; sync = 1'b0; adc_valid = 1'b0;
    adc_data = '0; clear = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    sbq.delete();
    mocc = 0;
  endtask

  // One cycle on instance B with scoreboard push/pop.
  task automatic stepb(input logic s, input logic v, input int d,
                       input logic r, input logic cap, input logic c);
    logic [13:0] e;
    bit rd, wr;
    sync = s; adc_valid = v; adc_data = 14'(d);
    out_ready = r; clear = c;
    chk("b_out_valid", b_out_valid, mocc > 0);
    rd = (mocc > 0) && r;
    wr = cap && v && (mocc < 16);
    if (rd) begin
      if (sbq.size() == 0) chk("b_sb_underflow", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("b_out_data", b_out_data, e);
      end
    end
    if (wr) sbq.push_back(14'(d));
    mocc = mocc + int'(wr) - int'(rd);
    @(posedge clk); #1;
    sync = 1'b0; clear = 1'b0;
  endtask

  task automatic drain_b(input logic v, output int pulses);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      stepb(1'b0, v, 700 + i, 1'b1, 1'b0, 1'b0);
      if (b_burst_done) pulses++;
    end
  endtask

  initial begin
    int pulses;
    int seen;
    n_pass = 0;
    n_total = 0;
    mocc = 0;

    reset = 1'b1; sync = 1'b0; adc_valid = 1'b0;
    adc_data = '0; clear = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", b_out_valid, 0);
    chk("rst_busy", b_busy, 0);
    chk("rst_done", b_burst_done, 0);
    chk("rst_frame", b_frame, 0);
    chk("rst_overflow", b_overflow, 0);
    chk("rst_resync", b_resync, 0);
    chk("rst_out_data", b_out_data, 0);
    chk("rst_a_busy", a_busy, 0);

    // short burst, streaming consumer
    do_reset();
    tbl[0] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[1] = mk(0, 1, 1, 1, 1, 1, 1, 0, 0);
    tbl[2] = mk(0, 1, 2, 1, 1, 1, 2, 0, 0);
    tbl[3] = mk(0, 1, 3, 1, 1, 1, 3, 0, 0);
    tbl[4] = mk(0, 1, 4, 1, 1, 1, 4, 0, 0);
    tbl[5] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[6] = mk(0, 0, 0, 1, 0, 0, 0, 1, 1);
    tbl[7] = mk(0, 0, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      sync = tbl[i].s; adc_valid = tbl[i].v;
      adc_data = tbl[i].d; out_ready = tbl[i].r;
      @(posedge clk); #1;
      chk($sformatf("t%0d_busy", i), a_busy, tbl[i].busy);
      chk($sformatf("t%0d_ovalid", i), a_out_valid, tbl[i].ov);
      if (tbl[i].ov)
        chk($sformatf("t%0d_odata", i), a_out_data, tbl[i].od);
      chk($sformatf("t%0d_done", i), a_burst_done, tbl[i].done);
      chk($sformatf("t%0d_frame", i), a_frame, tbl[i].fc);
    end

    // long burst into a stalled consumer, then drain
    do_reset();
    stepb(1'b1, 1'b1, 99, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      stepb(1'b0, 1'b1, 100 + i, 1'b0, 1'b1, 1'b0);
    chk("ovf_set", b_overflow, 1);
    chk("ovf_busy", b_busy, 1);
    chk("ovf_hold_data", b_out_data, 100);
    chk("ovf_sb_size", sbq.size(), 16);
    drain_b(1'b1, pulses);
    chk("ovf_done_pulses", pulses, 1);
    chk("ovf_frame", b_frame, 1);
    chk("ovf_sb_empty", sbq.size(), 0);
    chk("ovf_idle", b_busy, 0);
    stepb(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    chk("ovf_clear", b_overflow, 0);

    // resync during capture
    do_reset();
    stepb(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      stepb((i == 3) || (i == 6) || (i == 10), 1'b1, 300 + i,
            1'b1, 1'b1, i == 10);
      if (i == 3) chk("rse_set", b_resync, 1);
      if (i == 10) chk("rse_set_wins", b_resync, 1);
    end
    drain_b(1'b1, pulses);
    chk("rse_done_pulses", pulses, 1);
    chk("rse_frame", b_frame, 1);
    chk("rse_sticky", b_resync, 1);
    chk("rse_no_ovf", b_overflow, 0);
    stepb(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    chk("rse_clear", b_resync, 0);

    // full buffer with simultaneous read and write
    do_reset();
    stepb(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      stepb(1'b0, 1'b1, 400 + i, 1'b0, 1'b1, 1'b0);
    chk("full_no_ovf", b_overflow, 0);
    stepb(1'b0, 1'b1, 999, 1'b1, 1'b1, 1'b0);
    chk("full_ovf", b_overflow, 1);
    chk("full_occ", u_b.occ_q, 15);
    for (int i = 0; i < 3; i++)
      stepb(1'b0, 1'b1, 500 + i, 1'b0, 1'b1, 1'b0);
    drain_b(1'b0, pulses);
    chk("full_done_pulses", pulses, 1);
    chk("full_sb_empty", sbq.size(), 0);

    // reset mid-capture
    do_reset();
    stepb(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      stepb(1'b0, 1'b1, 200 + i, 1'b0, 1'b1, 1'b0);
    chk("mid_busy_pre", b_busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_ovalid", b_out_valid, 0);
    chk("mid_busy", b_busy, 0);
    chk("mid_odata", b_out_data, 0);
    sbq.delete();
    mocc = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++)
      stepb(1'b0, 1'b1, 600 + i, 1'b1, 1'b0, 1'b0);
    chk("mid_no_capture", b_busy, 0);

    // frame counter wrap over 256 short bursts
    do_reset();
    out_ready = 1'b1;
    seen = 0;
    for (int b = 0; b < 256; b++) begin
      sync = 1'b1; adc_valid = 1'b0;
      @(posedge clk); #1;
      sync = 1'b0;
      for (int k = 0; k < 4; k++) begin
        adc_valid = 1'b1; adc_data = 14'(k + b);
        @(posedge clk); #1;
      end
      adc_valid = 1'b0;
      for (int w = 0; w < 12; w++) begin
        @(posedge clk); #1;
        if (a_burst_done) begin
          seen++;
          break;
        end
      end
      if (b == 254) chk("wrap_255", a_frame, 255);
    end
    chk("wrap_bursts", seen, 256);
    chk("wrap_zero", a_frame, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
